pc_gen: RTL and testbench
=========================

# pc_gen

Program-counter generation stage for the single-clock RISC-V core. It owns the PC register and presents fetch addresses to instruction memory over a valid/ready handshake. It computes the next PC as sequential (PC+4), branch (branch PC + pre-shifted offset from the left-shift-by-one stage), or JALR target. Redirects that arrive while a fetch is stalled are buffered, and misaligned targets trap.

## Interface
- `n`, 32, datapath/address width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (must be 4-byte aligned)

- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `offset_shifted` in n: branch immediate already shifted left by 1 (bit 0 = 0)
- `branch_pc` in n: PC of the resolving branch
- `branch_taken` in 1: branch redirect request, single-cycle pulse
- `jalr_en` in 1: JALR redirect request, single-cycle pulse
- `jalr_target` in n: rs1+imm from the ALU
- `fetch_ready` in 1: instruction memory accepts `pc` this cycle
- `fetch_valid` out 1: `pc` is a valid fetch request
- `pc` out n: current fetch address (registered)
- `pc_plus4` out n: `pc + 4` (combinational from `pc`)
- `misalign_err` out 1: sticky trap flag
- `err_addr` out n: offending target address

## Operation
- fire = `fetch_valid & fetch_ready`.
- redir = `jalr_en | branch_taken`. JALR has priority when both are asserted.
- target = jalr_en ? {`jalr_target[n-1:1]`,1'b0} : `branch_pc + offset_shifted`. All sums are modulo 2^n, so wrap-around is silent.
- misaligned = redir & target[1].
- States: BOOT, RUN, PEND, TRAP.
- BOOT (after reset):
  - `fetch_valid`=0.
  - Redirects are ignored.
  - Unconditionally goes to RUN at the next edge.
- RUN (`fetch_valid`=1):
  - misaligned → TRAP; `err_addr`<=target, `misalign_err`<=1.
  - redir & fire → `pc`<=target; stay in RUN.
  - redir & !fire → `pend_q`<=target; go to PEND. `pc` holds, because a valid request must stay stable until accepted.
  - !redir & fire → `pc`<=`pc`+4.
  - otherwise → hold.
- PEND (`fetch_valid`=1, `pc` stable):
  - misaligned → TRAP, same as in RUN.
  - redir & !fire → `pend_q`<=new target (newest wins).
  - fire → `pc`<=(redir ? target : `pend_q`); go to RUN.
- TRAP:
  - `fetch_valid`=0; all inputs are ignored.
  - Exits only on reset.
- The instruction accepted in the same cycle as a redirect is wrong-path; decode squashes it. This block performs no squash.

## Timing
- Reset (async assert, sync use after deassert): `pc`=RESET_PC, `fetch_valid`=0, state=BOOT, `pend_q`=0, `misalign_err`=0, `err_addr`=0. `pc_plus4`=RESET_PC+4.
- The first request (`fetch_valid`=1, `pc`=RESET_PC) appears in the first cycle after the first post-reset edge.
- Redirect latency:
  - With fire: 1 cycle (target appears on `pc` after the next edge).
  - Without fire: applied at the edge of the first fire, then visible on the following cycle.
- `misalign_err` and `err_addr` update at the edge after the misaligned request. `fetch_valid` falls at the same edge.
- Reset mid-PEND or mid-TRAP discards the pending target and the error state immediately (asynchronous).
- All outputs are registered except `pc_plus4`.

## Structure
- Shared package `core_pkg`:
  - state enum `pc_state_t` {BOOT, RUN, PEND, TRAP}
  - `PC_INC`=4
- One sub-module, `branch_target_adder` (n-bit `branch_pc + offset_shifted`).
- The FSM, PC register, and pending register live in `pc_gen`.

## Test plan
- Reset with `fetch_ready`=1 held:
  - `pc` reads 0, 0, 4, 8, C on successive cycles.
  - `fetch_valid` is 0 in the first cycle and 1 thereafter.
- Taken branch with fire, at `pc`=0x10: `branch_pc`=0x08, `offset_shifted`=0x20 → next `pc`=0x28, then 0x2C.
- Redirect buffering:
  - At `pc`=0x40, `fetch_ready`=0, and a branch to 0x100 → `pc` stays 0x40 with `fetch_valid`=1.
  - Raise `fetch_ready` two cycles later → `pc`=0x100 after that edge.
- Back-to-back redirects in PEND: branch to 0x100, then JALR to 0x205 (giving target 0x204) before fire → after fire, `pc`=0x204.
- Simultaneous `jalr_en` and `branch_taken` → the JALR target wins.
- Misaligned branch target 0x1002 → `misalign_err`=1, `err_addr`=0x1002, `fetch_valid`=0 held until `rst_n` pulses low. The `rst_n` pulse is asserted asynchronously mid-cycle.
- Wrap-around: `pc`=0xFFFF_FFFC with fire → `pc`=0x0000_0000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core front end.
// Imported by the PC generation stage and its helpers.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND,
    TRAP
  } pc_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target adder: branch PC plus pre-shifted offset.
// Sum wraps modulo 2^n.
module branch_target_adder #(
  parameter int n = 32
) (
  input  logic [n-1:0] branch_pc,
  input  logic [n-1:0] offset_shifted,
  output logic [n-1:0] target
);

  assign target = branch_pc + offset_shifted;

endmodule

// File: rtl/pc_gen.sv
// PC generation stage: owns the PC and drives fetch requests.
// Buffers redirects while stalled; traps misaligned targets.
module pc_gen
  import core_pkg::*;
#(
  parameter int          n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] offset_shifted,
  input  logic [n-1:0] branch_pc,
  input  logic         branch_taken,
  input  logic         jalr_en,
  input  logic [n-1:0] jalr_target,
  input  logic         fetch_ready,
  output logic         fetch_valid,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic         misalign_err,
  output logic [n-1:0] err_addr
);

  pc_state_t    state_q;
  logic [n-1:0] pc_q;
  logic [n-1:0] pend_q;
  logic         valid_q;
  logic         err_q;
  logic [n-1:0] err_addr_q;

  logic [n-1:0] br_target;
  logic [n-1:0] target;
  logic         redir;
  logic         fire;
  logic         misaligned;
  logic         unused_jalr_lsb;

  branch_target_adder #(.n(n)) u_bta (
    .branch_pc      (branch_pc),
    .offset_shifted (offset_shifted),
    .target         (br_target)
  );

  // JALR clears bit 0 and wins over a simultaneous branch
  always_comb begin
    target = br_target;
    if (jalr_en) target = {jalr_target[n-1:1], 1'b0};
  end

  assign unused_jalr_lsb = jalr_target[0];
  assign redir      = jalr_en | branch_taken;
  assign fire       = valid_q & fetch_ready;
  assign misaligned = redir & target[1];

  // Fetch FSM with PC, pending-target and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (misaligned) begin
            state_q    <= TRAP;
            valid_q    <= 1'b0;
            err_q      <= 1'b1;
            err_addr_q <= target;
          end else if (redir && fire) begin
            pc_q <= target;
          end else if (redir) begin
            pend_q  <= target;
            state_q <= PEND;
          end else if (fire) begin
            pc_q <= pc_q + n'(PC_INC);
          end
        end
        PEND: begin
          if (misaligned) begin
            state_q    <= TRAP;
            valid_q    <= 1'b0;
            err_q      <= 1'b1;
            err_addr_q <= target;
          end else if (fire) begin
            pc_q    <= redir ? target : pend_q;
            state_q <= RUN;
          end else if (redir) begin
            pend_q <= target;
          end
        end
        TRAP: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= TRAP;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid  = valid_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + n'(PC_INC);
  assign misalign_err = err_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen.
// Drives and samples on the falling edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] offset_shifted;
  logic [31:0] branch_pc;
  logic        branch_taken;
  logic        jalr_en;
  logic [31:0] jalr_target;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  pc_gen #(.n(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .offset_shifted (offset_shifted),
    .branch_pc      (branch_pc),
    .branch_taken   (branch_taken),
    .jalr_en        (jalr_en),
    .jalr_target    (jalr_target),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .misalign_err   (misalign_err),
    .err_addr       (err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    branch_taken = 1'b0;
    jalr_en      = 1'b0;
  endtask

  task automatic br(input logic [31:0] bpc, input logic [31:0] off);
    branch_taken   = 1'b1;
    branch_pc      = bpc;
    offset_shifted = off;
  endtask

  task automatic jr(input logic [31:0] t);
    jalr_en     = 1'b1;
    jalr_target = t;
  endtask

  initial begin
    rst_n = 1'b0;
    offset_shifted = '0;
    branch_pc = '0;
    jalr_target = '0;
    fetch_ready = 1'b1;
    clr();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_err", {31'b0, misalign_err}, 32'd0);
    chk("rst_eaddr", err_addr, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    rst_n = 1'b1;
    tick();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'b0, fetch_valid}, 32'd1);
    tick(); chk("seq4", pc, 32'h4);
    tick(); chk("seq8", pc, 32'h8);
    tick(); chk("seqC", pc, 32'hC);
    tick(); chk("seq10", pc, 32'h10);

    br(32'h08, 32'h20);
    tick(); clr();
    chk("br_fire", pc, 32'h28);
    tick(); chk("br_seq", pc, 32'h2C);

    jr(32'h41);
    tick(); clr();
    chk("jalr_fire", pc, 32'h40);

    fetch_ready = 1'b0;
    br(32'h40, 32'hC0);
    tick(); clr();
    chk("pend_hold", pc, 32'h40);
    chk("pend_valid", {31'b0, fetch_valid}, 32'd1);
    tick(); chk("pend_hold2", pc, 32'h40);
    fetch_ready = 1'b1;
    tick(); chk("pend_apply", pc, 32'h100);
    tick(); chk("pend_seq", pc, 32'h104);

    fetch_ready = 1'b0;
    br(32'h80, 32'h80);
    tick(); clr();
    jr(32'h205);
    tick(); clr();
    chk("b2b_hold", pc, 32'h104);
    fetch_ready = 1'b1;
    tick(); chk("b2b_newest", pc, 32'h204);

    br(32'h0, 32'h500);
    jr(32'h300);
    tick(); clr();
    chk("jalr_prio", pc, 32'h300);

    fetch_ready = 1'b0;
    br(32'h80, 32'h80);
    tick(); clr();
    fetch_ready = 1'b1;
    jr(32'h400);
    tick(); clr();
    chk("pend_redir_fire", pc, 32'h400);

    br(32'hFFFF_FFF0, 32'h20);
    tick(); clr();
    chk("br_wrap", pc, 32'h10);

    jr(32'hFFFF_FFFC);
    tick(); clr();
    chk("pc_max", pc, 32'hFFFF_FFFC);
    chk("pc4_wrap", pc_plus4, 32'h0);
    tick(); chk("pc_wrap", pc, 32'h0);

    br(32'h1000, 32'h2);
    tick(); clr();
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_addr", err_addr, 32'h1002);
    chk("mis_valid", {31'b0, fetch_valid}, 32'd0);
    chk("mis_pc", pc, 32'h0);
    jr(32'h800);
    tick(); clr();
    tick();
    chk("trap_valid", {31'b0, fetch_valid}, 32'd0);
    chk("trap_pc", pc, 32'h0);
    chk("trap_err", {31'b0, misalign_err}, 32'd1);
    chk("trap_addr", err_addr, 32'h1002);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_err", {31'b0, misalign_err}, 32'd0);
    chk("arst_addr", err_addr, 32'h0);
    chk("arst_valid", {31'b0, fetch_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    br(32'h0, 32'h600);
    tick(); clr();
    chk("boot_ignore", pc, 32'h0);
    chk("boot_valid2", {31'b0, fetch_valid}, 32'd1);
    tick(); chk("restart_seq", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
